// File: rtl/single_add_arbiter_pkg.sv
// Shared constants and result record for the single-adder arbiter.
package single_add_arbiter_pkg;

    localparam int unsigned FLT_W       = 32;
    localparam int unsigned DEF_NREQ    = 4;
    localparam int unsigned DEF_ADD_LAT = 1;
    localparam int unsigned ID_MAX_W    = 8;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [FLT_W-1:0]    c;
    } result_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/single_add_1clk.sv
// IEEE-754 single-precision adder (round-to-nearest-even) with a LAT-stage output register chain.
module single_add_1clk
    import single_add_arbiter_pkg::*;
#(
    parameter int unsigned LAT = DEF_ADD_LAT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [FLT_W-1:0] a,
    input  logic [FLT_W-1:0] b,
    output logic             out_valid,
    output logic [FLT_W-1:0] c
);

    function automatic logic [FLT_W-1:0] fp_add(input logic [FLT_W-1:0] p, input logic [FLT_W-1:0] q);
        logic [31:0] x, y;
        logic [26:0] mx, my, my_sh, m;
        logic [53:0] wide;
        logic [27:0] sum;
        logic [30:0] mag;
        logic        up;
        int          ex, ey, d, e, lz, sh;
        if (p[30:0] >= q[30:0]) begin x = p; y = q; end
        else begin x = q; y = p; end
        if ((&x[30:23]) || (&y[30:23])) begin
            if ((&p[30:23] && |p[22:0]) || (&q[30:23] && |q[22:0]) ||
                (&p[30:23] && &q[30:23] && (p[31] != q[31])))
                return 32'h7FC0_0000;
            return x;
        end
        ex = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
        ey = (y[30:23] == 8'd0) ? 1 : int'(y[30:23]);
        mx = {|x[30:23], x[22:0], 3'b000};
        my = {|y[30:23], y[22:0], 3'b000};
        d  = ex - ey;
        // Alignment keeps guard/round bits and folds everything shifted past them into sticky.
        if (d >= 27) begin
            my_sh = {26'd0, |my};
        end else begin
            wide  = {my, 27'd0} >> d;
            my_sh = {wide[53:28], wide[27] | (|wide[26:0])};
        end
        sum = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my_sh}) : ({1'b0, mx} - {1'b0, my_sh});
        if (sum == '0)
            return {x[31] & y[31], 31'd0};
        e = ex;
        if (sum[27]) begin
            m = {sum[27:2], sum[1] | sum[0]};
            e = e + 1;
        end else begin
            lz = 0;
            for (int i = 0; i < 27; i++)
                if (sum[i]) lz = 26 - i;
            sh = (lz < e) ? lz : e - 1;
            m  = sum[26:0] << sh;
            e  = e - sh;
        end
        if (e >= 255)
            return {x[31], 8'hFF, 23'd0};
        up  = m[2] & (m[1] | m[0] | m[3]);
        // Rounding carry ripples into the exponent field, covering denormal->normal and overflow to inf.
        mag = {(m[26] ? 8'(e) : 8'd0), m[25:3]} + 31'(up);
        return {x[31], mag};
    endfunction

    logic [LAT-1:0]   stage_v;
    logic [FLT_W-1:0] stage_c [LAT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_v <= '0;
            for (int unsigned i = 0; i < LAT; i++)
                stage_c[i] <= '0;
        end else begin
            stage_v[0] <= in_valid;
            stage_c[0] <= fp_add(a, b);
            for (int unsigned i = 1; i < LAT; i++) begin
                stage_v[i] <= stage_v[i-1];
                stage_c[i] <= stage_c[i-1];
            end
        end
    end

    assign out_valid = stage_v[LAT-1];
    assign c         = stage_c[LAT-1];

endmodule

// File: rtl/single_add_arbiter.sv
// Round-robin arbiter sharing one float adder among NREQ requesters, with credit-limited result FIFO.
module single_add_arbiter
    import single_add_arbiter_pkg::*;
#(
    parameter int unsigned NREQ       = DEF_NREQ,
    parameter int unsigned ADD_LAT    = DEF_ADD_LAT,
    parameter int unsigned FIFO_DEPTH = ADD_LAT + 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NREQ-1:0]                   req_valid,
    output logic [NREQ-1:0]                   req_ready,
    input  logic [NREQ-1:0][FLT_W-1:0]        req_a,
    input  logic [NREQ-1:0][FLT_W-1:0]        req_b,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [idx_w(NREQ)-1:0]            res_id,
    output logic [FLT_W-1:0]                  res_c,
    output logic                              busy
);

    localparam int unsigned IDW = idx_w(NREQ);
    localparam int unsigned PW  = idx_w(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

    logic [IDW-1:0]   rr_ptr, grant;
    logic             granted, credit, xfer;
    logic [NREQ-1:0]  rotated;
    int unsigned      inflight;
    logic [FLT_W-1:0] add_a, add_b, add_c;
    logic             add_out_valid;

    logic [ADD_LAT-1:0] tag_v;
    logic [IDW-1:0]     tag_id [ADD_LAT];

    result_t        mem [FIFO_DEPTH];
    result_t        head;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  fifo_count;
    logic           push, pop;

    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < ADD_LAT; i++)
            inflight = inflight + 32'(tag_v[i]);
        credit = (32'(fifo_count) + inflight) < FIFO_DEPTH;

        rotated = NREQ'({req_valid, req_valid} >> rr_ptr);
        granted = 1'b0;
        grant   = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!granted && rotated[j]) begin
                granted = 1'b1;
                grant   = IDW'((32'(rr_ptr) + j) % NREQ);
            end
        end

        xfer      = granted && credit && !rst;
        req_ready = xfer ? (NREQ'(1) << grant) : '0;
        add_a     = xfer ? req_a[grant] : '0;
        add_b     = xfer ? req_b[grant] : '0;
    end

    single_add_1clk #(.LAT(ADD_LAT)) u_add (
        .clk       (clk),
        .rstn      (~rst),
        .in_valid  (xfer),
        .a         (add_a),
        .b         (add_b),
        .out_valid (add_out_valid),
        .c         (add_c)
    );

    assign push = tag_v[ADD_LAT-1];
    assign pop  = res_valid && res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            tag_v      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int unsigned i = 0; i < ADD_LAT; i++)
                tag_id[i] <= '0;
        end else begin
            if (xfer)
                rr_ptr <= IDW'((32'(grant) + 1) % NREQ);
            tag_v[0]  <= xfer;
            tag_id[0] <= grant;
            for (int unsigned i = 1; i < ADD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            if (push)
                wr_ptr <= (32'(wr_ptr) == FIFO_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= (32'(rd_ptr) == FIFO_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
            if (push && !pop)
                fifo_count <= fifo_count + CW'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{id: ID_MAX_W'(tag_id[ADD_LAT-1]), c: add_c};
    end

    assign head      = mem[rd_ptr];
    assign res_valid = (fifo_count != '0);
    assign res_id    = res_valid ? IDW'(head.id) : '0;
    assign res_c     = res_valid ? head.c : '0;
    assign busy      = (inflight != 0) || (fifo_count != '0);

    // The adder's own valid must line up with the tag pipeline that actually drives buffer writes.
    assert property (@(posedge clk) disable iff (rst) add_out_valid == tag_v[ADD_LAT-1]);

endmodule

// File: doc/single_add_arbiter.md
SINGLE_ADD_ARBITER -- requirements
Module: single_add_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one adder.
REQ-002 SHALL have parameter ADD_LAT, default 1, adder latency in clocks, in_valid to out_valid.
REQ-003 SHALL have parameter FIFO_DEPTH, default ADD_LAT+2, result buffer entries.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester operand valid.
REQ-007 req_ready  output  NREQ  per-requester accept; at most one bit high.
REQ-008 req_a  input  NREQ x 32  IEEE-754 single operand a per requester.
REQ-009 req_b  input  NREQ x 32  IEEE-754 single operand b per requester.
REQ-010 res_valid  output  1  result at buffer head.
REQ-011 res_ready  input  1  consumer accepts head.
REQ-012 res_id  output  clog2(NREQ)  requester index of head result.
REQ-013 res_c  output  32  a+b single-precision sum.
REQ-014 busy  output  1  high while any result is in flight or buffered.

Function
REQ-015 Transfer SHALL occur on requester i when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-016 Credit SHALL be available when fifo_count + inflight < FIFO_DEPTH; with no credit, req_ready SHALL be all zero.
REQ-017 With credit, grant SHALL go to the first i with req_valid[i], searching from rr_ptr upward and wrapping modulo NREQ; req_ready SHALL be combinational and one-hot on the grant.
REQ-018 On a transfer, rr_ptr SHALL become (grant+1) mod NREQ; with no transfer, rr_ptr SHALL hold.
REQ-019 The granted req_a/req_b SHALL drive the adder with in_valid=1 in the transfer cycle; otherwise in_valid=0 and operands 0.
REQ-020 Grant index and valid SHALL travel through an ADD_LAT-deep internal tag pipeline; the adder's out_valid SHALL NOT be used for buffer writes.
REQ-021 When the tag pipeline output is valid, {id, adder c} SHALL be pushed into the FIFO at that edge.
REQ-022 res_valid SHALL equal FIFO non-empty, with res_id/res_c showing the head; pop SHALL occur on res_valid & res_ready.
REQ-023 Latency SHALL be ADD_LAT+1 clocks from transfer edge to res_valid, with an empty FIFO.
REQ-024 Throughput SHALL be one transfer per clock while res_ready is held high.
REQ-025 On simultaneous push and pop, fifo_count SHALL be unchanged and order preserved; credit SHALL make push-on-full impossible.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; results SHALL leave in issue order.
REQ-027 busy SHALL be (inflight != 0) | (fifo_count != 0).

Reset
REQ-028 rst high SHALL immediately clear the following: rr_ptr=0, FIFO pointers and count=0, tag pipeline valids=0, res_valid=0, res_id=0, res_c=0, busy=0, req_ready=0.
REQ-029 Reset mid-operation SHALL discard in-flight and buffered results; no res_valid pulse for pre-reset operands after release.
REQ-030 The adder SHALL receive rstn = ~rst.

Structure
REQ-031 A shared package SHALL hold the float width constant (32), the default NREQ/ADD_LAT, and the result struct {id, c}.
REQ-032 The block SHALL instantiate exactly one sub-module, single_add_1clk; FIFO and tag pipeline SHALL be inline.

Verification
REQ-033 Single transfer: req0 a=0x3FC00000 (1.5), b=0x3FC00000 (1.5), res_ready=1 -> 2 clocks later res_valid, res_id=0, res_c=0x40400000 (3.0).
REQ-034 All four requesters valid in the same cycle: req0 1.5+1.5, req1 -1.5+-1.5, req2 2.0+-1.5, req3 150.0+-175.0 -> grants 0,1,2,3 on consecutive cycles; results 0x40400000, 0xC0400000, 0x3F000000, 0xC1C80000 in that order with matching ids.
REQ-035 Fairness: req1 and req3 held valid continuously -> grants alternate 1,3,1,3; no requester starved.
REQ-036 Backpressure: res_ready=0 with all requesters valid -> exactly FIFO_DEPTH transfers, then req_ready=0; raising res_ready drains results in order and resumes grants.
REQ-037 Reset during a burst: assert rst with 2 results buffered and 1 in flight -> outputs 0 at once; after release, no stale res_valid; a new 1.5+-1.5 returns 0x00000000 with correct id.
